// File: rtl/dsp_logic_simd_v4.sv
// Per-lane bitwise logic unit modelled on a DSP48E2 slice in FOUR12 SIMD logic mode.
// Optional per-lane zero flags are enabled with macro DSP_LOGIC_SIMD_ZERO_DETECT_EN.
module dsp_logic_simd_v4 #(
    parameter int WIDTH = 12,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [2:0]               i_op,
    input  logic [LANES*WIDTH-1:0]   i_a,
    input  logic [LANES*WIDTH-1:0]   i_b,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
`ifdef DSP_LOGIC_SIMD_ZERO_DETECT_EN
    output logic [LANES*WIDTH-1:0]   o_y,
    output logic [LANES-1:0]         o_zero
`else
    output logic [LANES*WIDTH-1:0]   o_y
`endif
);

    generate
        if (WIDTH < 1 || WIDTH > 12) begin : g_bad_width
            $error("dsp_logic_simd_v4: illegal WIDTH=%0d (legal 1..12)", WIDTH);
        end
        if (LANES < 1 || LANES > 4) begin : g_bad_lanes
            $error("dsp_logic_simd_v4: illegal LANES=%0d (legal 1..4)", LANES);
        end
    endgenerate

    logic [47:0] w_a48, w_b48, w_p_next;
    logic [3:0]  w_alumode;
    logic [8:0]  w_opmode;
    logic        w_en;

    logic        r_v1, r_v2;
    logic [47:0] r_ab, r_c, r_p;
    logic [3:0]  r_alumode;
    logic [8:0]  r_opmode;

    // Each lane sits in a 12-bit SIMD slot, zero-extended; empty slots are tied low.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            if (gi < LANES) begin : g_used
                assign w_a48[12*gi +: 12] = 12'(i_a[gi*WIDTH +: WIDTH]);
                assign w_b48[12*gi +: 12] = 12'(i_b[gi*WIDTH +: WIDTH]);
            end else begin : g_empty
                assign w_a48[12*gi +: 12] = 12'd0;
                assign w_b48[12*gi +: 12] = 12'd0;
            end
        end
    endgenerate

    // OPMODE = {W[1:0], Z[2:0], Y[1:0], X[1:0]}; Y=10 turns the logic unit's AND/XOR forms into OR/XNOR.
    always_comb begin
        w_alumode = 4'b0100;
        w_opmode  = 9'b00_011_00_11;
        case (i_op)
            3'd0: w_alumode = 4'b1100;
            3'd1: begin w_alumode = 4'b1100; w_opmode = 9'b00_011_10_11; end
            3'd2: w_alumode = 4'b0100;
            3'd3: w_alumode = 4'b0101;
            3'd4: w_alumode = 4'b1110;
            3'd5: begin w_alumode = 4'b1110; w_opmode = 9'b00_011_10_11; end
            3'd6: w_opmode = 9'b00_011_00_00;
            3'd7: w_opmode = 9'b00_000_00_11;
            default: ;
        endcase
    end

    function automatic logic [47:0] f_logic(input logic [47:0] x, input logic [47:0] z,
                                            input logic [1:0] ymode, input logic [3:0] alu);
        case ({ymode, alu})
            6'b00_0100: f_logic = x ^ z;
            6'b00_0101: f_logic = ~(x ^ z);
            6'b00_1100: f_logic = x & z;
            6'b00_1110: f_logic = ~(x & z);
            6'b10_0100: f_logic = ~(x ^ z);
            6'b10_0101: f_logic = x ^ z;
            6'b10_1100: f_logic = x | z;
            6'b10_1110: f_logic = ~(x | z);
            default:    f_logic = 48'd0;
        endcase
    endfunction

    always_comb begin
        w_p_next = f_logic((r_opmode[1:0] == 2'b11)  ? r_ab : 48'd0,
                           (r_opmode[6:4] == 3'b011) ? r_c  : 48'd0,
                           r_opmode[3:2], r_alumode);
    end

    assign w_en        = !r_v2 || i_out_ready;
    assign o_in_ready  = w_en;
    assign o_out_valid = r_v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_ab      <= 48'd0;
            r_c       <= 48'd0;
            r_alumode <= 4'd0;
            r_opmode  <= 9'd0;
            r_p       <= 48'd0;
        end else if (w_en) begin
            r_v1      <= i_in_valid;
            r_ab      <= w_b48;
            r_c       <= w_a48;
            r_alumode <= w_alumode;
            r_opmode  <= w_opmode;
            r_v2      <= r_v1;
            r_p       <= w_p_next;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_out
            assign o_y[gi*WIDTH +: WIDTH] = r_p[12*gi +: WIDTH];
        end
    endgenerate

    // Slot padding and the W mux field never reach an output.
    logic w_unused_bits;
    assign w_unused_bits = ^{r_p, r_opmode[8:7]};

`ifdef DSP_LOGIC_SIMD_ZERO_DETECT_EN
    logic [LANES-1:0] w_zero_next;
    logic [LANES-1:0] r_zero;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_zero
            assign w_zero_next[gi] = (w_p_next[12*gi +: WIDTH] == '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= '0;
        end else if (w_en) begin
            r_zero <= w_zero_next;
        end
    end

    assign o_zero = r_zero;
`endif

endmodule

// File: tb/tb_dsp_logic_simd_v4.sv
// Bench for dsp_logic_simd_v4: four geometries share one stimulus stream and a queue-based model.
// Zero-flag checks are compiled in when DSP_LOGIC_SIMD_ZERO_DETECT_EN is defined.
module tb_dsp_logic_simd_v4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [2:0]  op;
    logic [47:0] a, b;

    always #5 clk = ~clk;

    logic [47:0] y0;
    logic [23:0] y1;
    logic [9:0]  y2;
    logic [0:0]  y3;
    logic [3:0]  ov, ir;
    logic [47:0] ys [4];
    logic [3:0]  zs [4];

    int vectors = 0;
    int miscompares = 0;

    localparam int WS [4] = '{12, 8, 5, 1};
    localparam int LS [4] = '{4, 3, 2, 1};

`ifdef DSP_LOGIC_SIMD_ZERO_DETECT_EN
    logic [3:0] z0;
    logic [2:0] z1;
    logic [1:0] z2;
    logic [0:0] z3;
    always_comb begin
        zs[0] = z0; zs[1] = {1'b0, z1}; zs[2] = {2'b0, z2}; zs[3] = {3'b0, z3};
    end
    dsp_logic_simd_v4 #(.WIDTH(12), .LANES(4)) u0 (.clk(clk), .rst_n(rst_n), .i_in_valid(in_valid),
        .o_in_ready(ir[0]), .i_op(op), .i_a(a), .i_b(b), .o_out_valid(ov[0]),
        .i_out_ready(out_ready), .o_y(y0), .o_zero(z0));
    dsp_logic_simd_v4 #(.WIDTH(8), .LANES(3)) u1 (.clk(clk), .rst_n(rst_n), .i_in_valid(in_valid),
        .o_in_ready(ir[1]), .i_op(op), .i_a(a[23:0]), .i_b(b[23:0]), .o_out_valid(ov[1]),
        .i_out_ready(out_ready), .o_y(y1), .o_zero(z1));
    dsp_logic_simd_v4 #(.WIDTH(5), .LANES(2)) u2 (.clk(clk), .rst_n(rst_n), .i_in_valid(in_valid),
        .o_in_ready(ir[2]), .i_op(op), .i_a(a[9:0]), .i_b(b[9:0]), .o_out_valid(ov[2]),
        .i_out_ready(out_ready), .o_y(y2), .o_zero(z2));
    dsp_logic_simd_v4 #(.WIDTH(1), .LANES(1)) u3 (.clk(clk), .rst_n(rst_n), .i_in_valid(in_valid),
        .o_in_ready(ir[3]), .i_op(op), .i_a(a[0:0]), .i_b(b[0:0]), .o_out_valid(ov[3]),
        .i_out_ready(out_ready), .o_y(y3), .o_zero(z3));
`else
    always_comb begin
        zs[0] = 4'd0; zs[1] = 4'd0; zs[2] = 4'd0; zs[3] = 4'd0;
    end
    dsp_logic_simd_v4 #(.WIDTH(12), .LANES(4)) u0 (.clk(clk), .rst_n(rst_n), .i_in_valid(in_valid),
        .o_in_ready(ir[0]), .i_op(op), .i_a(a), .i_b(b), .o_out_valid(ov[0]),
        .i_out_ready(out_ready), .o_y(y0));
    dsp_logic_simd_v4 #(.WIDTH(8), .LANES(3)) u1 (.clk(clk), .rst_n(rst_n), .i_in_valid(in_valid),
        .o_in_ready(ir[1]), .i_op(op), .i_a(a[23:0]), .i_b(b[23:0]), .o_out_valid(ov[1]),
        .i_out_ready(out_ready), .o_y(y1));
    dsp_logic_simd_v4 #(.WIDTH(5), .LANES(2)) u2 (.clk(clk), .rst_n(rst_n), .i_in_valid(in_valid),
        .o_in_ready(ir[2]), .i_op(op), .i_a(a[9:0]), .i_b(b[9:0]), .o_out_valid(ov[2]),
        .i_out_ready(out_ready), .o_y(y2));
    dsp_logic_simd_v4 #(.WIDTH(1), .LANES(1)) u3 (.clk(clk), .rst_n(rst_n), .i_in_valid(in_valid),
        .o_in_ready(ir[3]), .i_op(op), .i_a(a[0:0]), .i_b(b[0:0]), .o_out_valid(ov[3]),
        .i_out_ready(out_ready), .o_y(y3));
`endif

    always_comb begin
        ys[0] = y0; ys[1] = {24'd0, y1}; ys[2] = {38'd0, y2}; ys[3] = {47'd0, y3};
    end

    // Reference: the operation is bitwise, so apply it to the whole packed vector and mask.
    function automatic logic [47:0] ref_y(input logic [2:0] o, input logic [47:0] x,
                                          input logic [47:0] y, input int w, input int l);
        logic [47:0] r;
        case (o)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = x ^ y;
            3'd3: r = ~(x ^ y);
            3'd4: r = ~(x & y);
            3'd5: r = ~(x | y);
            3'd6: r = x;
            default: r = y;
        endcase
        for (int k = w * l; k < 48; k++) r[k] = 1'b0;
        return r;
    endfunction

    function automatic logic [3:0] ref_zero(input logic [47:0] y, input int w, input int l);
        logic [3:0] z = 4'd0;
        for (int i = 0; i < l; i++) begin
            z[i] = 1'b1;
            for (int j = 0; j < w; j++) if (y[i*w + j]) z[i] = 1'b0;
        end
        return z;
    endfunction

    function automatic logic [47:0] rand48();
        return 48'({$urandom(), $urandom()});
    endfunction

    // Transaction model: an item is visible at the output once it has seen two advancing edges.
    typedef struct {
        logic [2:0]  op;
        logic [47:0] a;
        logic [47:0] b;
        int          adv;
    } txn_t;
    txn_t q[$];

    function automatic bit m_valid();
        return (q.size() > 0) && (q[0].adv >= 2);
    endfunction

    task automatic model_edge();
        if (!m_valid() || out_ready) begin
            if (m_valid()) void'(q.pop_front());
            foreach (q[i]) q[i].adv++;
            if (in_valid) q.push_back('{op, a, b, 1});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = '0; b = '0;
        #1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (ov[k] !== 1'b0 || ys[k] !== 48'd0 || ir[k] !== 1'b1 || zs[k] !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_state inst%0d: valid=%b y=%h ready=%b zero=%b, need 0/0/1/0",
                         k, ov[k], ys[k], ir[k], zs[k]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_or_latency();
        do_reset();
        in_valid = 1'b1; op = 3'd1; a = 48'h00F0F0F00001; b = 48'h0F000F0FF002;
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (ov[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL or_early_valid: out_valid=%b after 1 cycle, need 0", ov[0]);
        end
        tick();
        #1;
        vectors++;
        if (ov[0] !== 1'b1 || ys[0] !== 48'h0FF0FFFFF003) begin
            miscompares++;
            $display("FAIL or_result: valid=%b y=%h, need 1 y=0ff0fffff003", ov[0], ys[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [3];
        logic [47:0] exp [3];
        ops = '{3'd0, 3'd2, 3'd5};
        exp = '{48'h0F000F, 48'hF0FFF0, 48'h000000};
        do_reset();
        a = 48'hFFAA0F; b = 48'h0F55FF;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c < 3);
            if (c < 3) op = ops[c];
            #1;
            if (c >= 2) begin
                vectors++;
                if (ov[1] !== 1'b1 || ys[1] !== exp[c-2]) begin
                    miscompares++;
                    $display("FAIL b2b_w8l3 #%0d: valid=%b y=%h, need 1 y=%h", c - 2, ov[1], ys[1], exp[c-2]);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [47:0] sa [3];
        logic [47:0] sb [3];
        logic [2:0]  sop [3];
        logic [47:0] want;
        int idx = 0, acc = 0, pops = 0;
        bit took;
        for (int i = 0; i < 3; i++) begin
            sa[i] = rand48(); sb[i] = rand48(); sop[i] = 3'($urandom_range(0, 7));
        end
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; a = sa[idx]; b = sb[idx]; op = sop[idx];
            #1;
            took = ir[0];
            if (took) acc++;
            if (ov[0]) begin
                want = ref_y(sop[0], sa[0], sb[0], 12, 4);
                vectors++;
                if (ys[0] !== want) begin
                    miscompares++;
                    $display("FAIL stall_hold cyc%0d: y=%h, need %h", c, ys[0], want);
                end
            end
            tick();
            if (took) idx++;
        end
        #1;
        vectors++;
        if (acc !== 2 || ir[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_accepts: accepted=%0d in_ready=%b, need 2 and 0", acc, ir[0]);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 3);
            if (idx < 3) begin a = sa[idx]; b = sb[idx]; op = sop[idx]; end
            #1;
            took = in_valid && ir[0];
            if (ov[0]) begin
                vectors++;
                if (pops >= 3) begin
                    miscompares++;
                    $display("FAIL stall_dup: extra result y=%h, need none", ys[0]);
                end else begin
                    want = ref_y(sop[pops], sa[pops], sb[pops], 12, 4);
                    if (ys[0] !== want) begin
                        miscompares++;
                        $display("FAIL stall_order #%0d: y=%h, need %h", pops, ys[0], want);
                    end
                end
                pops++;
            end
            tick();
            if (took) idx++;
        end
        vectors++;
        if (pops !== 3) begin
            miscompares++;
            $display("FAIL stall_count: results=%0d, need 3", pops);
        end
    endtask

    task automatic test_reset_mid();
        logic [47:0] ra, rb, rc;
        ra = rand48(); rb = rand48(); rc = rand48();
        do_reset();
        in_valid = 1'b1; op = 3'd2; a = ra; b = rb;
        tick();
        op = 3'd7; a = rb; b = ra;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        vectors++;
        if (ov[0] !== 1'b1 || ys[0] !== ref_y(3'd2, ra, rb, 12, 4)) begin
            miscompares++;
            $display("FAIL midrst_first: valid=%b y=%h, need 1 y=%h", ov[0], ys[0], ref_y(3'd2, ra, rb, 12, 4));
        end
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ov[0] !== 1'b0 || ys[0] !== 48'd0 || ir[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_clear: valid=%b y=%h ready=%b, need 0/0/1", ov[0], ys[0], ir[0]);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        q.delete();
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (ov[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_stale cyc%0d: out_valid=%b y=%h, need 0", c, ov[0], ys[0]);
            end
            tick();
        end
        in_valid = 1'b1; op = 3'd6; a = rc; b = ra;
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        vectors++;
        if (ov[0] !== 1'b1 || ys[0] !== rc) begin
            miscompares++;
            $display("FAIL midrst_first_after: valid=%b y=%h, need 1 y=%h", ov[0], ys[0], rc);
        end
    endtask

`ifdef DSP_LOGIC_SIMD_ZERO_DETECT_EN
    task automatic test_zero();
        do_reset();
        in_valid = 1'b1; op = 3'd2; a = 48'h123456789ABC; b = 48'h123456789ABC;
        tick();
        op = 3'd0; a = 48'hFFFFFFFFFFFF; b = 48'h123456789000;
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (ys[0] !== 48'd0 || zs[0] !== 4'b1111) begin
            miscompares++;
            $display("FAIL zero_all: y=%h zero=%b, need 0 and 1111", ys[0], zs[0]);
        end
        tick();
        #1;
        vectors++;
        if (zs[0] !== 4'b0001) begin
            miscompares++;
            $display("FAIL zero_lane0: zero=%b, need 0001", zs[0]);
        end
    endtask
`endif

    task automatic test_random();
        int acc = 0;
        int cyc = 0;
        logic [47:0] want;
        do_reset();
        while (acc < 10000 && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            a = rand48(); b = rand48();
            #1;
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (ir[k] !== (!m_valid() || out_ready) || ov[k] !== m_valid()) begin
                    miscompares++;
                    $display("FAIL rand_hs inst%0d cyc%0d: ready=%b valid=%b, need %b %b",
                             k, cyc, ir[k], ov[k], (!m_valid() || out_ready), m_valid());
                end
                if (m_valid()) begin
                    want = ref_y(q[0].op, q[0].a, q[0].b, WS[k], LS[k]);
                    vectors++;
                    if (ys[k] !== want) begin
                        miscompares++;
                        $display("FAIL rand_y inst%0d cyc%0d: y=%h, need %h", k, cyc, ys[k], want);
                    end
`ifdef DSP_LOGIC_SIMD_ZERO_DETECT_EN
                    vectors++;
                    if (zs[k] !== ref_zero(want, WS[k], LS[k])) begin
                        miscompares++;
                        $display("FAIL rand_zero inst%0d cyc%0d: zero=%b, need %b",
                                 k, cyc, zs[k], ref_zero(want, WS[k], LS[k]));
                    end
`endif
                end
            end
            if (in_valid && ir[0]) acc++;
            tick();
            cyc++;
        end
        vectors++;
        if (acc < 10000) begin
            miscompares++;
            $display("FAIL rand_budget: accepted=%0d in %0d cycles, need 10000", acc, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_or_latency();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef DSP_LOGIC_SIMD_ZERO_DETECT_EN
        test_zero();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dsp_logic_simd_v4.md
DSP_LOGIC_SIMD_V4 -- requirements
Module: dsp_logic_simd_v4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, meaning per-lane bit width (legal 1..12).
REQ-002 The block SHALL have parameter LANES, default 4, meaning number of SIMD lanes (legal 1..4).
REQ-003 Illegal WIDTH or LANES SHALL raise an elaboration-time error naming the offending value.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = asserted).
REQ-006 in_valid  input  1  request carries valid a, b, op.
REQ-007 in_ready  output  1  block accepts the request this cycle.
REQ-008 op  input  3  operation code (see REQ-013).
REQ-009 a  input  LANES*WIDTH  packed operand A; lane i at bits [i*WIDTH +: WIDTH].
REQ-010 b  input  LANES*WIDTH  packed operand B, same packing.
REQ-011 out_valid  output  1  y holds a result.
REQ-012 out_ready  input  1  consumer takes the result this cycle; y  output  LANES*WIDTH  packed result, same packing.

Function
REQ-013 op SHALL select per-lane bitwise y=f(a,b): 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 pass A, 7 pass B.
REQ-014 The datapath SHALL be one DSP48E2 in FOUR12 SIMD mode, using logic ALUMODE/OPMODE with the multiplier unused; C carries A and A:B carries B.
REQ-015 Lane i SHALL occupy DSP slot bits [12*i +: 12], zero-extended from WIDTH; unused slots and bits [47:12*LANES] SHALL be driven 0.
REQ-016 No lane SHALL affect another lane's result; y lane i SHALL equal P[12*i +: WIDTH].
REQ-017 Pipeline SHALL be two stages: input registers (A, B, C, ALUMODE, OPMODE) and PREG, each with a valid bit.
REQ-018 Global advance enable SHALL be en = !out_valid || out_ready; in_ready SHALL equal en.
REQ-019 A transfer SHALL occur when in_valid && in_ready; its result SHALL appear with out_valid=1 exactly 2 cycles later when out_ready stays high.
REQ-020 When en=0, all pipeline registers SHALL hold, and y SHALL remain stable while out_valid=1.
REQ-021 When en=1, bubbles (in_valid=0) SHALL propagate as valid=0 stages.
REQ-022 Sustained throughput SHALL be one result per cycle with in_valid=out_ready=1.
REQ-023 op SHALL be registered with its operands, so per-transaction op changes take effect without stalls or corruption of in-flight results.
REQ-024 A simultaneous output pop and input push SHALL both complete in the same cycle.

Reset
REQ-025 Assertion of reset SHALL asynchronously clear both valid bits and all data and control registers to 0, giving out_valid=0 and y=0.
REQ-026 While reset is asserted, in_ready SHALL be 1, and no transfer SHALL be recorded.
REQ-027 Reset mid-operation SHALL discard all in-flight results.
REQ-028 The first accept after deassertion SHALL yield a result at the normal 2-cycle latency.

Configuration
REQ-029 With macro DSP_LOGIC_SIMD_ZERO_DETECT_EN defined, the block SHALL add output zero (LANES bits).
REQ-030 zero[i] SHALL be 1 iff y lane i is all zeros, registered alongside y, reset to 0, and held under stall.
REQ-031 Without DSP_LOGIC_SIMD_ZERO_DETECT_EN, port zero and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-032 WIDTH=12, LANES=4, op=1, a=0x00F_0F0_F00_001, b=0x0F0_00F_0FF_002, out_ready=1 -> 2 cycles later out_valid=1, y=0x0FF_0FF_FFF_003.
REQ-033 WIDTH=8, LANES=3, back-to-back ops 0,2,5 on a=0xFF_AA_0F, b=0x0F_55_FF -> y=0x0F_00_0F, then 0xF0_FF_F0, then 0x00_00_00, in consecutive cycles.
REQ-034 Hold out_ready=0 for 5 cycles with 3 requests offered -> exactly 2 accepted, in_ready=0, y stable; on release, results emerge in order with none lost or duplicated.
REQ-035 Assert reset in the cycle after a result appears with out_valid=1 and a second result in flight -> out_valid=0 and y=0 immediately; no stale result after deassertion.
REQ-036 With DSP_LOGIC_SIMD_ZERO_DETECT_EN, op=2 and a=b=0x123_456_789_ABC -> y=0 and zero=4'b1111; op=0 with lane0 of b=0 -> zero[0]=1 only.
REQ-037 A random regression of 10k transactions with random ops, operands, valid and ready patterns, run over all WIDTH/LANES corners (1/1, 12/4, 5/2), SHALL match a golden model cycle-accurately.
